// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and lane widths.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Unsigned byte/halfword variants only exist for loads.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       lane,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] merged
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: BYTE_W];
    half_sel = word[{lane[1], 4'b0000} +: HALF_W];

    rdata = word;
    case (funct3)
      F3_B:    rdata = {{(WIDTH-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_BU:   rdata = {{(WIDTH-BYTE_W){1'b0}}, byte_sel};
      F3_H:    rdata = {{(WIDTH-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      F3_HU:   rdata = {{(WIDTH-HALF_W){1'b0}}, half_sel};
      default: rdata = word;
    endcase

    // Word stores ignore the captured word entirely.
    merged = wdata;
    case (funct3)
      F3_B: begin
        merged = word;
        merged[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      F3_H: begin
        merged = word;
        merged[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_engine.sv
// Load/store unit FSM: request latch, memory read/RMW sequencing, response handshake.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning them down.
module lsu_engine
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_t           state;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] word_q;
  logic             err_q;

  logic             accept;
  logic             trap;
  logic [1:0]       lane_in;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] merged_word;

  assign accept = req_valid && req_ready;

  // An access is misaligned exactly when forcing its low bits changes them.
  always_comb begin
    lane_in = req_addr[1:0];
    case (req_funct3)
      F3_H, F3_HU: lane_in[0] = 1'b0;
      F3_W:        lane_in    = 2'b00;
      default:     lane_in    = req_addr[1:0];
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    trap = f3_illegal(req_we, req_funct3) || (lane_in != req_addr[1:0]);
`else
    trap = f3_illegal(req_we, req_funct3);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            err_q <= trap;
            if (trap)
              state <= S_RESP;
            else if (req_we && req_funct3 == F3_W)
              state <= S_WR;
            else
              state <= S_RD;
          end
        end
        S_RD:    state <= we_q ? S_WR : S_RESP;
        S_WR:    state <= S_RESP;
        S_RESP:  if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= {req_addr[WIDTH-1:2], lane_in};
      wdata_q  <= req_wdata;
    end
    if (state == S_RD)
      word_q <= mem_rdata;
  end

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .word   (word_q),
    .wdata  (wdata_q),
    .lane   (addr_q[1:0]),
    .funct3 (funct3_q),
    .rdata  (load_data),
    .merged (merged_word)
  );

  assign req_ready    = (state == S_IDLE) && !rst;
  assign mem_read_en  = (state == S_RD);
  assign mem_write_en = (state == S_WR);
  assign mem_addr     = (state == S_RD || state == S_WR) ? {2'b00, addr_q[WIDTH-1:2]} : '0;
  assign mem_wdata    = (state == S_WR) ? merged_word : '0;
  assign rsp_valid    = (state == S_RESP);
  assign rsp_err      = (state == S_RESP) && err_q;
  assign rsp_rdata    = (state == S_RESP && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_engine.sv
// Self-checking bench for lsu_engine: directed scenarios plus random traffic against a byte-array model.
module tb_lsu_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_engine #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_addr[3:0]] <= mem_wdata;

  logic [7:0] ref_b [64];
  int cmps = 0;
  int errs = 0;

  int          o_lat, o_rd, o_wr;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic        o_err;
  bit          o_stable, o_ready_low, o_bad_strobe;

  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit illegal, mis;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    mis = (int'(addr) % ref_size(f3)) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    return illegal || mis;
`else
    if (mis) return illegal;
    return illegal;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int sz, ea;
    logic [31:0] v;
    sz = ref_size(f3);
    ea = int'(addr) - (int'(addr) % sz);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_b[ea + i]) << (8 * i));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int sz, ea;
    sz = ref_size(f3);
    ea = int'(addr) - (int'(addr) % sz);
    for (int i = 0; i < sz; i++) ref_b[ea + i] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // Issues one request and records what the DUT did up to the response handshake.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold);
    int n;
    o_lat = 0; o_rd = 0; o_wr = 0; o_addr = 0; o_wdata = 0;
    o_stable = 1; o_ready_low = 1; o_bad_strobe = 0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1 req_valid = 0;
    while (1) begin
      @(negedge clk);
      o_lat++;
      if (req_ready) o_ready_low = 0;
      if (mem_read_en && mem_write_en) o_bad_strobe = 1;
      if (rsp_valid) begin
        if (mem_read_en || mem_write_en) o_bad_strobe = 1;
        break;
      end
      if (mem_read_en) begin o_rd++; o_addr = mem_addr; end
      if (mem_write_en) begin o_wr++; o_addr = mem_addr; o_wdata = mem_wdata; end
      if (o_lat >= 10) break;
    end
    o_rdata = rsp_rdata; o_err = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== o_rdata || rsp_err !== o_err || req_ready) o_stable = 0;
    end
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmps++; if (req_ready !== 1'b0) begin errs++; $display("FAIL reset_ready_in_rst got=%b exp=0", req_ready); end
    cmps++; if ({rsp_valid, rsp_err, mem_read_en, mem_write_en} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctrl got=%b exp=0000", {rsp_valid, rsp_err, mem_read_en, mem_write_en}); end
    cmps++; if ((rsp_rdata | mem_addr | mem_wdata) !== 32'h0) begin
      errs++; $display("FAIL reset_data got=%h/%h/%h exp=0", rsp_rdata, mem_addr, mem_wdata); end
    rst = 0;
    @(negedge clk);
    cmps++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready_after got=%b exp=1", req_ready); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd5, 3'd1};
    logic [31:0] adrs [4] = '{32'h11, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFFAA, 32'h00000088, 32'h00008899, 32'hFFFFAABB};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, f3s[i], adrs[i], 32'h0, 0);
      cmps++; if (o_rdata !== exps[i] || o_err !== 1'b0) begin
        errs++; $display("FAIL load%0d_data got=%h err=%b exp=%h err=0", i, o_rdata, o_err, exps[i]); end
      cmps++; if (o_lat !== 2 || o_rd !== 1 || o_wr !== 0 || o_addr !== 32'd4) begin
        errs++; $display("FAIL load%0d_timing got lat=%0d rd=%0d wr=%0d addr=%h exp 2/1/0/4", i, o_lat, o_rd, o_wr, o_addr); end
    end
  endtask

  task automatic test_misalign();
    do_op(1'b0, 3'd2, 32'h11, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    cmps++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_lat !== 1 || (o_rd + o_wr) !== 0) begin
      errs++; $display("FAIL misalign_trap got err=%b data=%h lat=%0d strobes=%0d exp 1/0/1/0", o_err, o_rdata, o_lat, o_rd + o_wr); end
`else
    cmps++; if (o_err !== 1'b0 || o_rdata !== 32'h8899AABB || o_lat !== 2 || o_addr !== 32'd4) begin
      errs++; $display("FAIL misalign_fix got err=%b data=%h lat=%0d addr=%h exp 0/8899aabb/2/4", o_err, o_rdata, o_lat, o_addr); end
`endif
  endtask

  task automatic test_sub_store();
    do_op(1'b1, 3'd1, 32'h12, 32'h00001234, 0);
    ref_store(3'd1, 32'h12, 32'h00001234);
    cmps++; if (o_wdata !== 32'h1234AABB || o_addr !== 32'd4) begin
      errs++; $display("FAIL sh_wdata got=%h addr=%h exp=1234aabb addr=4", o_wdata, o_addr); end
    cmps++; if (o_lat !== 3 || o_rd !== 1 || o_wr !== 1 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      errs++; $display("FAIL sh_timing got lat=%0d rd=%0d wr=%0d err=%b exp 3/1/1/0", o_lat, o_rd, o_wr, o_err); end
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 0);
    cmps++; if (o_rdata !== 32'h1234AABB) begin errs++; $display("FAIL lw_after_sh got=%h exp=1234aabb", o_rdata); end
  endtask

  task automatic test_backpressure();
    int n;
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 3);
    cmps++; if (!o_stable || o_rdata !== ref_load(3'd2, 32'h10)) begin
      errs++; $display("FAIL backpressure got stable=%0d data=%h exp stable=1 data=%h", o_stable, o_rdata, ref_load(3'd2, 32'h10)); end
    cmps++; if (req_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
    req_valid = 1; req_we = 0; req_funct3 = 3'd4; req_addr = 32'h10;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    cmps++; if (mem_read_en !== 1'b1 || req_ready !== 1'b0) begin
      errs++; $display("FAIL b2b_accept got rd=%b ready=%b exp 1/0", mem_read_en, req_ready); end
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    cmps++; if (rsp_rdata !== ref_load(3'd4, 32'h10)) begin
      errs++; $display("FAIL b2b_data got=%h exp=%h", rsp_rdata, ref_load(3'd4, 32'h10)); end
    rsp_ready = 1; @(posedge clk); #1 rsp_ready = 0;
  endtask

  task automatic test_illegal();
    logic        wes [2] = '{1'b0, 1'b1};
    logic [2:0]  f3s [2] = '{3'd3, 3'd5};
    for (int i = 0; i < 2; i++) begin
      do_op(wes[i], f3s[i], 32'h10, 32'hDEADBEEF, 0);
      cmps++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_lat !== 1 || (o_rd + o_wr) !== 0) begin
        errs++; $display("FAIL illegal%0d got err=%b data=%h lat=%0d strobes=%0d exp 1/0/1/0", i, o_err, o_rdata, o_lat, o_rd + o_wr); end
    end
    cmps++; if (mem[4] !== ref_word(4)) begin errs++; $display("FAIL illegal_mem got=%h exp=%h", mem[4], ref_word(4)); end
  endtask

  task automatic test_reset_midop();
    bit wr_seen;
    wr_seen = 0;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    cmps++; if (mem_read_en !== 1'b1) begin errs++; $display("FAIL rmw_rd_phase got=%b exp=1", mem_read_en); end
    rst = 1;
    @(negedge clk);
    wr_seen = wr_seen | mem_write_en;
    cmps++; if (req_ready !== 1'b0) begin errs++; $display("FAIL midop_ready_in_rst got=%b exp=0", req_ready); end
    rst = 0;
    @(negedge clk);
    wr_seen = wr_seen | mem_write_en;
    cmps++; if (req_ready !== 1'b1 || wr_seen) begin
      errs++; $display("FAIL midop_abort got ready=%b wr_seen=%0d exp 1/0", req_ready, wr_seen); end
    cmps++; if (mem[4] !== ref_word(4)) begin errs++; $display("FAIL midop_mem got=%h exp=%h", mem[4], ref_word(4)); end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_d;
    bit          e;
    int          exp_lat;
    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 63));
      wd = $urandom;
      e = ref_err(we, f3, addr);
      exp_d = (e || we) ? 32'h0 : ref_load(f3, addr);
      exp_lat = e ? 1 : ((we && f3 != 3'd2) ? 3 : 2);
      do_op(we, f3, addr, wd, $urandom_range(0, 2));
      if (!e && we) ref_store(f3, addr, wd);
      cmps++; if (o_rdata !== exp_d || o_err !== e || o_lat !== exp_lat || !o_stable || !o_ready_low || o_bad_strobe) begin
        errs++; $display("FAIL rand%0d we=%b f3=%0d a=%h got d=%h e=%b lat=%0d exp d=%h e=%b lat=%0d", k, we, f3, addr,
                         o_rdata, o_err, o_lat, exp_d, e, exp_lat); end
      cmps++; if (o_rd !== ((!e && !(we && f3 == 3'd2)) ? 1 : 0) || o_wr !== ((!e && we) ? 1 : 0)) begin
        errs++; $display("FAIL rand%0d_strobes got rd=%0d wr=%0d", k, o_rd, o_wr); end
      cmps++; if (mem[addr[5:2]] !== ref_word(int'(addr[5:2]))) begin
        errs++; $display("FAIL rand%0d_mem got=%h exp=%h", k, mem[addr[5:2]], ref_word(int'(addr[5:2]))); end
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    for (int i = 0; i < 16; i++) mem[i] = (i == 4) ? 32'h8899AABB : $urandom;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'(mem[i / 4] >> (8 * (i % 4)));
    test_reset();
    test_loads();
    test_misalign();
    test_sub_store();
    test_backpressure();
    test_illegal();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
